// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset stage sequencer: FSM state encoding and the
// default phase lengths also used by the power-on reset controller.
package rst_seq_pkg;

    localparam logic [1:0] ST_ASSERT    = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int DEF_HOLD_CYCLES = 1024;
    localparam int DEF_LOCK_STABLE = 32;
    localparam int DEF_ACK_TIMEOUT = 65535;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear, enable and terminal-value compare; one
// instance is time-shared by the hold, lock-stable and ack-timeout phases.
module rst_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_term
);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == terminal);

endmodule

// File: rtl/rst_stage_sequencer.sv
// Releases downstream stage resets one at a time, waiting for each stage's
// ready ack (or a timeout) before the next; re-enters reset on soft reset or lock loss.
module rst_stage_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sw_rst_req,
    input  logic                          pll_locked,
    input  logic [NUM_STAGES-1:0]         stage_ready,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic                          timeout_err,
    output logic [$clog2(NUM_STAGES)-1:0] timeout_stage
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    logic [1:0]            state_r, state_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic                  err_r, err_nxt_s;
    logic [IDX_W-1:0]      tstage_r, tstage_nxt_s;
    logic [NUM_STAGES-1:0] stage_rst_n_r, stage_rst_n_nxt_s;
    logic                  seq_done_r;
    logic                  tmr_clr_s, tmr_en_s, tmr_hit_s;
    logic [CNT_W-1:0]      tmr_term_s;
    logic                  ready_cur_s;

    assign ready_cur_s = stage_ready[idx_r];

    rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr_s),
        .en       (tmr_en_s),
        .terminal (tmr_term_s),
        .at_term  (tmr_hit_s)
    );

    // Terminal count for whichever phase currently owns the timer.
    always_comb begin
        tmr_term_s = CNT_W'(ACK_TIMEOUT - 1);
        case (state_r)
            ST_ASSERT:    tmr_term_s = CNT_W'(HOLD_CYCLES - 1);
            ST_WAIT_LOCK: tmr_term_s = CNT_W'(LOCK_STABLE - 1);
            ST_RELEASE:   tmr_term_s = CNT_W'(ACK_TIMEOUT - 1);
            default:      tmr_term_s = CNT_W'(ACK_TIMEOUT - 1);
        endcase
    end

    // Next-state, stage index, error tracking and timer control.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        err_nxt_s    = err_r;
        tstage_nxt_s = tstage_r;
        tmr_clr_s    = 1'b0;
        tmr_en_s     = 1'b0;
        case (state_r)
            ST_ASSERT: begin
                if (sw_rst_req) begin
                    tmr_clr_s = 1'b1;
                end else if (tmr_hit_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    tmr_clr_s   = 1'b1;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (sw_rst_req) begin
                    state_nxt_s  = ST_ASSERT;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    err_nxt_s    = 1'b0;
                    tstage_nxt_s = {IDX_W{1'b0}};
                    tmr_clr_s    = 1'b1;
                end else if (!pll_locked) begin
                    tmr_clr_s = 1'b1;
                end else if (tmr_hit_s) begin
                    state_nxt_s = ST_RELEASE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    tmr_clr_s   = 1'b1;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (sw_rst_req) begin
                    state_nxt_s  = ST_ASSERT;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    err_nxt_s    = 1'b0;
                    tstage_nxt_s = {IDX_W{1'b0}};
                    tmr_clr_s    = 1'b1;
                end else if (!pll_locked) begin
                    state_nxt_s = ST_ASSERT;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    tmr_clr_s   = 1'b1;
                end else if (ready_cur_s || tmr_hit_s) begin
                    // An ack on the timeout cycle counts as a normal ack.
                    if (!ready_cur_s) begin
                        err_nxt_s    = 1'b1;
                        tstage_nxt_s = idx_r;
                    end else begin
                        err_nxt_s    = err_r;
                        tstage_nxt_s = tstage_r;
                    end
                    tmr_clr_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                tmr_clr_s = 1'b1;
                if (sw_rst_req) begin
                    state_nxt_s  = ST_ASSERT;
                    idx_nxt_s    = {IDX_W{1'b0}};
                    err_nxt_s    = 1'b0;
                    tstage_nxt_s = {IDX_W{1'b0}};
                end else if (!pll_locked) begin
                    state_nxt_s = ST_ASSERT;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_ASSERT;
                idx_nxt_s   = {IDX_W{1'b0}};
                tmr_clr_s   = 1'b1;
            end
        endcase
    end

    // Thermometer decode of the next state so the reset outputs can be registered.
    always_comb begin
        stage_rst_n_nxt_s = {NUM_STAGES{1'b0}};
        case (state_nxt_s)
            ST_RELEASE: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    stage_rst_n_nxt_s[k] = (k <= int'(idx_nxt_s));
                end
            end
            ST_DONE: stage_rst_n_nxt_s = {NUM_STAGES{1'b1}};
            default: stage_rst_n_nxt_s = {NUM_STAGES{1'b0}};
        endcase
    end

    // State, index, error and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_ASSERT;
            idx_r         <= {IDX_W{1'b0}};
            err_r         <= 1'b0;
            tstage_r      <= {IDX_W{1'b0}};
            stage_rst_n_r <= {NUM_STAGES{1'b0}};
            seq_done_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            err_r         <= err_nxt_s;
            tstage_r      <= tstage_nxt_s;
            stage_rst_n_r <= stage_rst_n_nxt_s;
            seq_done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign stage_rst_n   = stage_rst_n_r;
    assign seq_done      = seq_done_r;
    assign seq_busy      = ~seq_done_r;
    assign timeout_err   = err_r;
    assign timeout_stage = tstage_r;

endmodule

// File: tb/tb_rst_stage_sequencer.sv
// Randomized self-checking bench for rst_stage_sequencer against a phase-level
// model that counts cycles spent in each phase and the number of released stages.
module tb_rst_stage_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int LOCK = 4;
    localparam int ACK  = 20;

    localparam int P_HOLD = 0;
    localparam int P_LOCK = 1;
    localparam int P_REL  = 2;
    localparam int P_DONE = 3;

    localparam logic [8:0] RESET_VEC = 9'h010;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic         pll_locked = 1'b0;
    logic [N-1:0] stage_ready = '0;
    logic [N-1:0] stage_rst_n;
    logic         seq_busy, seq_done, timeout_err;
    logic [1:0]   timeout_stage;

    int vectors = 0;
    int miscompares = 0;

    int         dly [N];
    int         age [N];
    logic [N-1:0] ack_en = '1;

    int         m_phase, m_elapsed, m_rel;
    logic       m_err;
    logic [1:0] m_tstage;

    always #5 clk = ~clk;

    rst_stage_sequencer #(
        .NUM_STAGES  (N),
        .HOLD_CYCLES (HOLD),
        .LOCK_STABLE (LOCK),
        .ACK_TIMEOUT (ACK),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst_req    (sw_rst_req),
        .pll_locked    (pll_locked),
        .stage_ready   (stage_ready),
        .stage_rst_n   (stage_rst_n),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .timeout_err   (timeout_err),
        .timeout_stage (timeout_stage)
    );

    // Reference model: phase, cycles spent in it, and how many stages are released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_HOLD; m_elapsed <= 0; m_rel <= 0; m_err <= 1'b0; m_tstage <= 2'd0;
        end else if (m_phase == P_HOLD) begin
            if (sw_rst_req) m_elapsed <= 0;
            else if (m_elapsed + 1 == HOLD) begin m_phase <= P_LOCK; m_elapsed <= 0; end
            else m_elapsed <= m_elapsed + 1;
        end else if (sw_rst_req) begin
            m_phase <= P_HOLD; m_elapsed <= 0; m_rel <= 0; m_err <= 1'b0; m_tstage <= 2'd0;
        end else if (!pll_locked && m_phase != P_LOCK) begin
            m_phase <= P_HOLD; m_elapsed <= 0; m_rel <= 0;
        end else if (m_phase == P_LOCK) begin
            if (!pll_locked) m_elapsed <= 0;
            else if (m_elapsed + 1 == LOCK) begin m_phase <= P_REL; m_rel <= 1; m_elapsed <= 0; end
            else m_elapsed <= m_elapsed + 1;
        end else if (m_phase == P_REL) begin
            if (stage_ready[m_rel-1] || m_elapsed + 1 == ACK) begin
                if (!stage_ready[m_rel-1]) begin m_err <= 1'b1; m_tstage <= 2'(m_rel - 1); end
                m_elapsed <= 0;
                if (m_rel == N) m_phase <= P_DONE;
                else m_rel <= m_rel + 1;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    function automatic logic [8:0] exp_vec();
        logic [N-1:0] therm;
        therm = N'((1 << m_rel) - 1);
        return {therm, m_phase != P_DONE, m_phase == P_DONE, m_err, m_tstage};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {stage_rst_n, seq_busy, seq_done, timeout_err, timeout_stage};
    endfunction

    // Each stage acks dly[k] cycles after its reset is seen released (if enabled).
    task automatic respond();
        for (int k = 0; k < N; k++) begin
            if (!stage_rst_n[k]) begin
                age[k] = 0;
                stage_ready[k] = 1'b0;
            end else begin
                age[k] = age[k] + 1;
                stage_ready[k] = ack_en[k] && (age[k] >= dly[k]);
            end
        end
    endtask

    task automatic do_reset(input logic lock);
        @(negedge clk);
        rst_n = 1'b0; sw_rst_req = 1'b0; pll_locked = lock; stage_ready = '0;
        for (int k = 0; k < N; k++) age[k] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_values obs=%h exp=%h", obs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_nominal();
        int cyc;
        for (int k = 0; k < N; k++) dly[k] = 3;
        ack_en = '1;
        do_reset(1'b1);
        for (int e = 1; e <= HOLD + LOCK; e++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL nominal_cycle edge=%0d obs=%h exp=%h", e, obs_vec(), exp_vec());
            end
            respond();
        end
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL nominal_first_release obs=%b exp=0001", stage_rst_n);
        end
        cyc = 0;
        while (m_phase != P_DONE && cyc < 200) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL nominal_seq obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
            cyc++;
        end
        @(negedge clk);
        vectors++;
        if ({seq_done, seq_busy, timeout_err, stage_rst_n} !== 7'b1001111) begin
            miscompares++;
            $display("FAIL nominal_done obs=%b exp=1001111", {seq_done, seq_busy, timeout_err, stage_rst_n});
        end
    endtask

    task automatic test_lock_glitch();
        for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 5);
        do_reset(1'b1);
        repeat (HOLD + 2) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_pre obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
        end
        pll_locked = 1'b0;
        @(negedge clk);
        respond();
        pll_locked = 1'b1;
        for (int e = 1; e <= LOCK; e++) begin
            @(negedge clk);
            vectors++;
            if (stage_rst_n !== ((e == LOCK) ? 4'b0001 : 4'b0000) || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_release edge=%0d obs=%h exp=%h", e, obs_vec(), exp_vec());
            end
            respond();
        end
    endtask

    task automatic test_timeout();
        int cyc;
        for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 4);
        ack_en = 4'b1101;
        do_reset(1'b1);
        cyc = 0;
        while (m_phase != P_DONE && cyc < 300) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL timeout_seq obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
            cyc++;
        end
        @(negedge clk);
        vectors++;
        if ({seq_done, timeout_err, timeout_stage} !== 4'b1101) begin
            miscompares++;
            $display("FAIL timeout_flag obs=%b exp=1101", {seq_done, timeout_err, timeout_stage});
        end
        respond();
        ack_en = '1;
    endtask

    task automatic test_soft_reset_done();
        int cyc;
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        vectors++;
        if ({stage_rst_n, seq_busy, seq_done, timeout_err, timeout_stage} !== RESET_VEC) begin
            miscompares++;
            $display("FAIL soft_reset_entry obs=%h exp=%h", obs_vec(), RESET_VEC);
        end
        respond();
        for (int e = 1; e <= HOLD + LOCK; e++) begin
            @(negedge clk);
            vectors++;
            if (stage_rst_n !== ((e == HOLD + LOCK) ? 4'b0001 : 4'b0000) || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL soft_reset_repeat edge=%0d obs=%h exp=%h", e, obs_vec(), exp_vec());
            end
            respond();
        end
        cyc = 0;
        while (m_phase != P_DONE && cyc < 200) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL soft_reset_seq obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
            cyc++;
        end
    endtask

    task automatic test_lock_loss();
        int cyc;
        for (int k = 0; k < N; k++) dly[k] = 2;
        ack_en = 4'b1110;
        do_reset(1'b1);
        cyc = 0;
        while (m_rel != 3 && cyc < 200) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lockloss_seq obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
            cyc++;
        end
        pll_locked = 1'b0;
        @(negedge clk);
        vectors++;
        if ({stage_rst_n, seq_busy, seq_done, timeout_err, timeout_stage} !== 9'h014) begin
            miscompares++;
            $display("FAIL lockloss_entry obs=%h exp=014", obs_vec());
        end
        respond();
        pll_locked = 1'b1;
        ack_en = '1;
    endtask

    task automatic test_boundary();
        int cyc;
        dly[0] = ACK; dly[1] = 6; dly[2] = 2; dly[3] = 2;
        ack_en = '1;
        do_reset(1'b1);
        cyc = 0;
        while (m_rel != 2 && cyc < 200) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL boundary_seq obs=%h exp=%h", obs_vec(), exp_vec());
            end
            respond();
            cyc++;
        end
        @(negedge clk);
        vectors++;
        if ({stage_rst_n, timeout_err} !== 5'b00110) begin
            miscompares++;
            $display("FAIL boundary_ack_on_timeout obs=%b exp=00110", {stage_rst_n, timeout_err});
        end
        respond();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset_mid_release obs=%h exp=%h", obs_vec(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 25);
            ack_en = 4'($urandom_range(0, 15)) | 4'b0001;
            do_reset(1'b1);
            repeat (600) begin
                @(negedge clk);
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random_run%0d obs=%h exp=%h", run, obs_vec(), exp_vec());
                end
                respond();
                sw_rst_req = ($urandom_range(0, 149) == 0);
                pll_locked = ($urandom_range(0, 99) != 0);
            end
            sw_rst_req = 1'b0;
            pll_locked = 1'b1;
        end
        ack_en = '1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin dly[k] = 3; age[k] = 0; end
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_timeout();
        test_soft_reset_done();
        test_lock_loss();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
